// File: rtl/vec_wb_pkg.sv
// Shared types and helpers for the vector register-file writeback controller:
// the buffered result entry, LMUL encodings and register-group legality rules.
package vec_wb_pkg;

    localparam int VLEN              = 512;
    localparam int MAX_VEC_REGISTERS = 32;
    localparam int ADDR_WIDTH        = 5;
    localparam int DATA_WIDTH        = 8 * VLEN;

    localparam logic [3:0] LMUL_1 = 4'b0001;
    localparam logic [3:0] LMUL_2 = 4'b0010;
    localparam logic [3:0] LMUL_4 = 4'b0100;
    localparam logic [3:0] LMUL_8 = 4'b1000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] vd;
        logic [3:0]            lmul;
        logic                  legal;
    } wb_entry_t;

    // Number of registers in the group; 0 flags an encoding that is not one-hot.
    function automatic int lmul_to_int(input logic [3:0] lmul);
        case (lmul)
            LMUL_1:  return 1;
            LMUL_2:  return 2;
            LMUL_4:  return 4;
            LMUL_8:  return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic group_legal(input logic [ADDR_WIDTH-1:0] vd,
                                         input logic [3:0]            lmul);
        int n;
        int v;
        n = lmul_to_int(lmul);
        v = int'(vd);
        return (n != 0) && ((v & (n - 1)) == 0) && (v + n <= MAX_VEC_REGISTERS);
    endfunction

    function automatic logic [MAX_VEC_REGISTERS-1:0] group_mask(input logic [ADDR_WIDTH-1:0] vd,
                                                                input logic [3:0]            lmul);
        logic [MAX_VEC_REGISTERS-1:0] ones;
        ones = MAX_VEC_REGISTERS'((64'(1) << lmul_to_int(lmul)) - 64'd1);
        return ones << vd;
    endfunction

endpackage

// File: rtl/vec_wb_fifo.sv
// Synchronous FIFO of writeback entries with flush; pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate flag.
module vec_wb_fifo
    import vec_wb_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              push_data,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    wb_entry_t   mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vec_wb_ctrl.sv
// Vector register-file writeback controller: buffers LMUL-grouped results,
// drops misaligned groups with an error pulse, and tracks pending writes per register.
module vec_wb_ctrl
    import vec_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         res_valid,
    output logic                         res_ready,
    input  logic [DATA_WIDTH-1:0]        res_data,
    input  logic [ADDR_WIDTH-1:0]        res_vd,
    input  logic [3:0]                   res_lmul,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        waddr,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic [3:0]                   lmul,
    output logic [MAX_VEC_REGISTERS-1:0] busy_mask,
    output logic                         err_valid,
    output logic [ADDR_WIDTH-1:0]        err_vd
);

    localparam int CW = $clog2(FIFO_DEPTH + 2);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t                    push_entry;
    wb_entry_t                    head;
    logic                         push;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [FW-1:0]                fifo_count;
    logic [CW-1:0]                pend_cnt [MAX_VEC_REGISTERS];
    logic [MAX_VEC_REGISTERS-1:0] inc_mask;
    logic [MAX_VEC_REGISTERS-1:0] dec_mask;
    logic [DATA_WIDTH-1:0]        head_data_masked;
    int                           head_n;

    assign res_ready = reset && !flush && !fifo_full;
    assign push      = res_valid && res_ready;

    always_comb begin
        push_entry.data  = res_data;
        push_entry.vd    = res_vd;
        push_entry.lmul  = res_lmul;
        push_entry.legal = group_legal(res_vd, res_lmul);
    end

    vec_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .pop       (!fifo_empty),
        .push_data (push_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Registers beyond the group never receive stale bits from the wide result bus.
    always_comb begin
        head_n           = lmul_to_int(head.lmul);
        head_data_masked = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < head_n) head_data_masked[k*VLEN +: VLEN] = head.data[k*VLEN +: VLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en     <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            lmul      <= LMUL_1;
            err_valid <= 1'b0;
            err_vd    <= '0;
        end else if (flush) begin
            wr_en     <= 1'b0;
            err_valid <= 1'b0;
        end else if (!fifo_empty) begin
            if (head.legal) begin
                wr_en     <= 1'b1;
                waddr     <= head.vd;
                wdata     <= head_data_masked;
                lmul      <= head.lmul;
                err_valid <= 1'b0;
            end else begin
                wr_en     <= 1'b0;
                err_valid <= 1'b1;
                err_vd    <= head.vd;
            end
        end else begin
            wr_en     <= 1'b0;
            err_valid <= 1'b0;
        end
    end

    // The decrement keys off the registered write, so a register stays busy
    // through the cycle in which the file actually commits it.
    assign inc_mask = (push && push_entry.legal) ? group_mask(res_vd, res_lmul) : '0;
    assign dec_mask = wr_en ? group_mask(waddr, lmul) : '0;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int r = 0; r < MAX_VEC_REGISTERS; r++) pend_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < MAX_VEC_REGISTERS; r++)
                pend_cnt[r] <= pend_cnt[r] + CW'(inc_mask[r]) - CW'(dec_mask[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            for (int r = 0; r < MAX_VEC_REGISTERS; r++)
                assert (!(dec_mask[r] && !inc_mask[r] && (pend_cnt[r] == '0)));
            assert (fifo_count <= FW'(FIFO_DEPTH));
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < MAX_VEC_REGISTERS; r++) busy_mask[r] = (pend_cnt[r] != '0);
    end

endmodule

// File: tb/tb_vec_wb_ctrl.sv
// Self-checking bench for vec_wb_ctrl: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vec_wb_ctrl;
    import vec_wb_pkg::*;

    localparam int DW = DATA_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [4:0]    res_vd;
    logic [3:0]    res_lmul;
    logic          wr_en;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    lmul;
    logic [31:0]   busy_mask;
    logic          err_valid;
    logic [4:0]    err_vd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_wb_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_vd    (res_vd),
        .res_lmul  (res_lmul),
        .wr_en     (wr_en),
        .waddr     (waddr),
        .wdata     (wdata),
        .lmul      (lmul),
        .busy_mask (busy_mask),
        .err_valid (err_valid),
        .err_vd    (err_vd)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            vd;
        int            n;
        logic [3:0]    lmul;
        bit            legal;
    } mentry_t;

    mentry_t       mq[$];
    bit            model_on = 1'b0;
    logic          exp_wr_en;
    logic          exp_err_valid;
    int            exp_waddr;
    int            exp_n;
    int            exp_err_vd;
    logic [3:0]    exp_lmul;
    logic [DW-1:0] exp_wdata;

    function automatic int group_size(input logic [3:0] l);
        case (l)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] keep_low_regs(input logic [DW-1:0] d, input int n);
        logic [DW-1:0] m;
        m = '1;
        m = m >> (DW - n * VLEN);
        return d & m;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b;
        b = '0;
        if (exp_wr_en) for (int i = 0; i < exp_n; i++) b[exp_waddr + i] = 1'b1;
        foreach (mq[j])
            if (mq[j].legal) for (int i = 0; i < mq[j].n; i++) b[mq[j].vd + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [7:0] b);
        return {(DW/8){b}};
    endfunction

    // Reference model: a queue of accepted results, popped one per cycle.
    always @(posedge clk) begin
        mentry_t e;
        mentry_t h;
        bit      accept;
        if (!reset) begin
            mq.delete();
            exp_wr_en     = 1'b0;
            exp_waddr     = 0;
            exp_n         = 1;
            exp_wdata     = '0;
            exp_lmul      = 4'b0001;
            exp_err_valid = 1'b0;
            exp_err_vd    = 0;
            model_on      = 1'b1;
        end else if (flush) begin
            mq.delete();
            exp_wr_en     = 1'b0;
            exp_err_valid = 1'b0;
        end else begin
            accept = res_valid && (mq.size() < 4);
            if (accept) begin
                e.data  = res_data;
                e.vd    = int'(res_vd);
                e.lmul  = res_lmul;
                e.n     = group_size(res_lmul);
                e.legal = (e.n != 0) && (e.vd % e.n == 0) && (e.vd + e.n <= 32);
            end
            if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.legal) begin
                    exp_wr_en     = 1'b1;
                    exp_waddr     = h.vd;
                    exp_n         = h.n;
                    exp_lmul      = h.lmul;
                    exp_wdata     = keep_low_regs(h.data, h.n);
                    exp_err_valid = 1'b0;
                end else begin
                    exp_wr_en     = 1'b0;
                    exp_err_valid = 1'b1;
                    exp_err_vd    = h.vd;
                end
            end else begin
                exp_wr_en     = 1'b0;
                exp_err_valid = 1'b0;
            end
            if (accept) mq.push_back(e);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        int first;
        int base;
        checks++;
        if (act !== exp) begin
            first = 0;
            for (int i = DW - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            base = (first / 64) * 64;
            errors++;
            $display("[TB] FAIL %s: bits [%0d+:64] got %0h expected %0h at %0t",
                     name, base, act[base +: 64], exp[base +: 64], $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("res_ready", 64'(res_ready), 64'(reset && !flush && (mq.size() < 4)));
            checkOutput("wr_en", 64'(wr_en), 64'(exp_wr_en));
            checkOutput("err_valid", 64'(err_valid), 64'(exp_err_valid));
            checkOutput("busy_mask", 64'(busy_mask), 64'(exp_busy()));
            if (exp_wr_en) begin
                checkOutput("waddr", 64'(waddr), 64'(exp_waddr));
                checkOutput("lmul", 64'(lmul), 64'(exp_lmul));
                checkWide("wdata", wdata, exp_wdata);
            end
            if (exp_err_valid) checkOutput("err_vd", 64'(err_vd), 64'(exp_err_vd));
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] vd, input logic [3:0] l,
                                 input logic [DW-1:0] d, input logic f);
        res_valid = v;
        res_vd    = vd;
        res_lmul  = l;
        res_data  = d;
        flush     = f;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 4'b0001, '0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    int         vds[5]  = '{1, 3, 3, 16, 20};
    logic [3:0] lms[5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) nextCycle();

        $display("[TB] reset values");
        checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst_waddr", 64'(waddr), 64'd0);
        checkWide("rst_wdata", wdata, '0);
        checkOutput("rst_lmul", 64'(lmul), 64'd1);
        checkOutput("rst_err_valid", 64'(err_valid), 64'd0);
        checkOutput("rst_err_vd", 64'(err_vd), 64'd0);
        checkOutput("rst_busy", 64'(busy_mask), 64'd0);
        checkOutput("rst_ready", 64'(res_ready), 64'd0);
        reset = 1'b1;
        nextCycle();

        $display("[TB] single LMUL=1 write");
        applyStimulus(1'b1, 5'd5, 4'b0001, pattern(8'hA5), 1'b0);
        nextCycle();
        checkOutput("t1_e0_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t1_e0_busy", 64'(busy_mask), 64'h20);
        idle();
        nextCycle();
        checkOutput("t1_e1_wr_en", 64'(wr_en), 64'd1);
        checkOutput("t1_e1_waddr", 64'(waddr), 64'd5);
        checkOutput("t1_e1_busy", 64'(busy_mask), 64'h20);
        checkOutput("t1_wdata_lo", wdata[63:0], 64'hA5A5A5A5A5A5A5A5);
        checkOutput("t1_wdata_hi", wdata[575:512], 64'd0);
        nextCycle();
        checkOutput("t1_e2_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t1_e2_busy", 64'(busy_mask), 64'd0);

        $display("[TB] LMUL=4 group");
        applyStimulus(1'b1, 5'd8, 4'b0100, pattern(8'h3C), 1'b0);
        nextCycle();
        checkOutput("t2_e0_busy", 64'(busy_mask), 64'hF00);
        idle();
        nextCycle();
        checkOutput("t2_e1_wr_en", 64'(wr_en), 64'd1);
        checkOutput("t2_e1_waddr", 64'(waddr), 64'd8);
        checkOutput("t2_e1_lmul", 64'(lmul), 64'h4);
        checkOutput("t2_e1_busy", 64'(busy_mask), 64'hF00);
        checkOutput("t2_wdata_top_kept", wdata[2047:1984], 64'h3C3C3C3C3C3C3C3C);
        checkOutput("t2_wdata_above0", wdata[2111:2048], 64'd0);
        checkOutput("t2_wdata_above1", wdata[4095:4032], 64'd0);
        nextCycle();
        checkOutput("t2_e2_busy", 64'(busy_mask), 64'd0);

        $display("[TB] illegal groups");
        applyStimulus(1'b1, 5'd6, 4'b0100, pattern(8'h11), 1'b0);
        nextCycle();
        checkOutput("t3_e0_busy", 64'(busy_mask), 64'd0);
        applyStimulus(1'b1, 5'd28, 4'b1000, pattern(8'h22), 1'b0);
        nextCycle();
        checkOutput("t3_e1_err", 64'(err_valid), 64'd1);
        checkOutput("t3_e1_err_vd", 64'(err_vd), 64'd6);
        checkOutput("t3_e1_wr_en", 64'(wr_en), 64'd0);
        applyStimulus(1'b1, 5'd7, 4'b0011, pattern(8'h33), 1'b0);
        nextCycle();
        checkOutput("t3_e2_err", 64'(err_valid), 64'd1);
        checkOutput("t3_e2_err_vd", 64'(err_vd), 64'd28);
        idle();
        nextCycle();
        checkOutput("t3_e3_err", 64'(err_valid), 64'd1);
        checkOutput("t3_e3_err_vd", 64'(err_vd), 64'd7);
        checkOutput("t3_e3_busy", 64'(busy_mask), 64'd0);
        nextCycle();
        checkOutput("t3_e4_err", 64'(err_valid), 64'd0);
        checkOutput("t3_e4_wr_en", 64'(wr_en), 64'd0);

        $display("[TB] back-to-back pushes");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'(vds[i]), lms[i], pattern(8'(8'h40 + i)), 1'b0);
            checkOutput("t4_ready", 64'(res_ready), 64'd1);
            nextCycle();
            if (i == 3) begin
                checkOutput("t4_e3_waddr", 64'(waddr), 64'd3);
                checkOutput("t4_e3_busy3", 64'(busy_mask[3]), 64'd1);
            end
            if (i == 4) begin
                checkOutput("t4_e4_waddr", 64'(waddr), 64'd16);
                checkOutput("t4_e4_busy", 64'(busy_mask), 64'h00F30000);
            end
        end
        idle();
        nextCycle();
        checkOutput("t4_e5_wr_en", 64'(wr_en), 64'd1);
        checkOutput("t4_e5_waddr", 64'(waddr), 64'd20);
        checkOutput("t4_e5_lmul", 64'(lmul), 64'h4);
        nextCycle();
        checkOutput("t4_e6_busy", 64'(busy_mask), 64'd0);

        $display("[TB] flush mid-stream");
        applyStimulus(1'b1, 5'd10, 4'b0001, pattern(8'h5A), 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd12, 4'b0001, pattern(8'h6B), 1'b0);
        nextCycle();
        checkOutput("t5_e1_wr_en", 64'(wr_en), 64'd1);
        checkOutput("t5_e1_waddr", 64'(waddr), 64'd10);
        checkOutput("t5_e1_busy", 64'(busy_mask), 64'h1400);
        applyStimulus(1'b1, 5'd14, 4'b0001, pattern(8'h7C), 1'b1);
        #1;
        checkOutput("t5_flush_ready", 64'(res_ready), 64'd0);
        nextCycle();
        checkOutput("t5_e2_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t5_e2_busy", 64'(busy_mask), 64'd0);
        idle();
        nextCycle();
        checkOutput("t5_e3_wr_en", 64'(wr_en), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 5'd2, 4'b0010, pattern(8'h99), 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd4, 4'b0010, pattern(8'h88), 1'b0);
        nextCycle();
        checkOutput("t6_e1_busy", 64'(busy_mask), 64'h3C);
        idle();
        reset = 1'b0;
        nextCycle();
        checkOutput("t6_rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t6_rst_waddr", 64'(waddr), 64'd0);
        checkOutput("t6_rst_lmul", 64'(lmul), 64'd1);
        checkOutput("t6_rst_busy", 64'(busy_mask), 64'd0);
        checkOutput("t6_rst_wdata", wdata[63:0], 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("t6_ready_after", 64'(res_ready), 64'd1);
        nextCycle();
        checkOutput("t6_e3_wr_en", 64'(wr_en), 64'd0);
        repeat (2) nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
